fifo_rd_stream: RTL

- Read-side controller for the team's synchronous FIFO (cs/rd_en/dataout/empty interface, registered dataout with 1-cycle read latency).
- Issues FIFO reads, absorbs the read latency in a 3-entry skid buffer and presents words on a valid/ready stream.
- Sustains 1 word/clk under continuous m_ready, with no combinational path from m_ready to fifo_rd_en.
- Sits between a FIFO instance and any downstream stream consumer.

---
 rtl/fifo_rd_stream.sv | 92 +++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// FIFO read-side streamer: issues reads, absorbs 1-cycle read latency.
// Optional beat counter enabled by RD_STREAM_CNT_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dataout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef RD_STREAM_CNT_EN
  input  logic                  cnt_clr,
  output logic [15:0]           word_cnt,
`endif
  output logic                  drained
);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [1:0]            r_head;
  logic [1:0]            r_tail;
  logic [DATA_WIDTH-1:0] r_mem [3];

  logic [2:0] w_level;
  logic [1:0] w_occ_nxt;
  logic       w_pop;

  function automatic logic [1:0] f_nxt(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words held plus word in flight; reads stop once 3 are committed.
  assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight};
  assign fifo_rd_en = rst_n & en & ~fifo_empty
                    & (w_level <= 3'd2);
  assign fifo_cs    = rst_n & en;

  assign m_valid = rst_n & (r_occ != 2'd0);
  assign m_data  = r_mem[r_head];
  assign w_pop   = m_valid & m_ready;
  assign drained = fifo_empty & (r_occ == 2'd0)
                 & ~r_inflight;

  assign w_occ_nxt = r_occ + {1'b0, r_inflight}
                   - {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_inflight <= fifo_rd_en;
      r_occ      <= w_occ_nxt;
      if (r_inflight) begin
        r_mem[r_tail] <= fifo_dataout;
        r_tail        <= f_nxt(r_tail);
      end
      if (w_pop) begin
        r_head <= f_nxt(r_head);
      end
    end
  end

`ifdef RD_STREAM_CNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word_cnt <= 16'd0;
    end else if (cnt_clr) begin
      r_word_cnt <= 16'd0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule
